dec_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch/decode/execute front end. Watches the instruction held in decode and the instruction in execute. Generates fetch/decode stall, a decode-to-execute bubble and the registered flush qualifier consumed by decode as its flush input. Covers load-use hazards not solvable by the EXE/RF fast-forward paths, LSU back-pressure, CSR/xRET serialization and branch/trap flush.

---
 rtl/dec_pipe_ctrl_pkg.sv | 13 +
 rtl/dec_pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_dec_pipe_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dec_pipe_ctrl_pkg.sv
// Shared types and constants for the decode pipeline sequencing controller.
package dec_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    SERIAL   = 2'd2,
    FLUSH    = 2'd3
  } pipe_state_t;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/dec_pipe_ctrl.sv
// Fetch/decode stall, decode bubble and registered flush sequencing.
// Optional perf counters enabled by defining DEC_PIPE_CTRL_PERF_EN.
module dec_pipe_ctrl
  import dec_pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid_i,
  input  logic             dec_rs1_v_i,
  input  logic [4:0]       dec_rs1_adr_i,
  input  logic             dec_rs2_v_i,
  input  logic [4:0]       dec_rs2_adr_i,
  input  logic             dec_serial_i,
  input  logic             exe_rd_v_q_i,
  input  logic [4:0]       exe_rd_adr_q_i,
  input  logic             exe_is_load_q_i,
  input  logic             exe_lsu_busy_i,
  input  logic             exe_flush_req_i,
  output logic             if_stall_o,
  output logic             dec_stall_o,
  output logic             dec_bubble_o,
  output logic             flush_v_q_o,
`ifdef DEC_PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] perf_ld_stall_o,
  output logic [CNT_W-1:0] perf_serial_stall_o,
  output logic [CNT_W-1:0] perf_flush_o,
`endif
  output logic [1:0]       state_q_o
);

  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES);

  pipe_state_t state_q;
  logic [3:0]  cnt_q;
  logic        flush_v_q;
  logic        ld_use;
  logic        stall;
  logic        bubble;

  always_comb begin
    ld_use = dec_valid_i & exe_is_load_q_i & exe_rd_v_q_i & (exe_rd_adr_q_i != '0) &
             ((dec_rs1_v_i & (dec_rs1_adr_i == exe_rd_adr_q_i)) |
              (dec_rs2_v_i & (dec_rs2_adr_i == exe_rd_adr_q_i)));
  end

  // LSU back-pressure freezes execute, so it stalls without injecting a bubble.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    unique case (state_q)
      RUN: begin
        stall  = ld_use | exe_lsu_busy_i;
        bubble = ld_use & ~exe_lsu_busy_i;
      end
      LD_STALL: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      SERIAL: begin
        stall  = (cnt_q != '0);
        bubble = (cnt_q != '0);
      end
      default: ;
    endcase
    if (exe_flush_req_i) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end
  end

  // Leaving SERIAL on the last drain cycle makes the counter-zero cycle unstalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      flush_v_q <= 1'b0;
    end else begin
      flush_v_q <= exe_flush_req_i;
      if (exe_flush_req_i) begin
        state_q <= FLUSH;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (exe_lsu_busy_i) begin
              state_q <= RUN;
            end else if (ld_use) begin
              state_q <= LD_STALL;
            end else if (dec_valid_i & dec_serial_i) begin
              state_q <= SERIAL;
              cnt_q   <= DrainInit;
            end
          end
          LD_STALL: state_q <= RUN;
          SERIAL: begin
            if (cnt_q <= 4'd1) begin
              state_q <= RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign if_stall_o   = stall;
  assign dec_stall_o  = stall;
  assign dec_bubble_o = bubble;
  assign flush_v_q_o  = flush_v_q;
  assign state_q_o    = state_q;

`ifdef DEC_PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_ld_q;
  logic [CNT_W-1:0] perf_ser_q;
  logic [CNT_W-1:0] perf_fl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld_q  <= '0;
      perf_ser_q <= '0;
      perf_fl_q  <= '0;
    end else begin
      if ((state_q == LD_STALL) && (perf_ld_q != '1)) perf_ld_q <= perf_ld_q + 1'b1;
      if ((state_q == SERIAL) && stall && (perf_ser_q != '1)) perf_ser_q <= perf_ser_q + 1'b1;
      if (flush_v_q && (perf_fl_q != '1)) perf_fl_q <= perf_fl_q + 1'b1;
    end
  end

  assign perf_ld_stall_o     = perf_ld_q;
  assign perf_serial_stall_o = perf_ser_q;
  assign perf_flush_o        = perf_fl_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_dec_pipe_ctrl.sv
// Scoreboard bench for dec_pipe_ctrl: directed per-cycle vectors, decoupled monitor.
module tb_dec_pipe_ctrl;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       flush_v;
    logic [1:0] state;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, rs1_v, rs2_v, serial;
  logic [4:0] rs1_adr, rs2_adr, rd_adr;
  logic       rd_v, is_load, lsu_busy, flush_req;
  logic       if_stall, dec_stall, dec_bubble, flush_v_q;
  logic [1:0] state_q;
`ifdef DEC_PIPE_CTRL_PERF_EN
  logic [31:0] perf_ld, perf_ser, perf_fl;
`endif

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dec_pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .dec_valid_i     (dec_valid),
    .dec_rs1_v_i     (rs1_v),
    .dec_rs1_adr_i   (rs1_adr),
    .dec_rs2_v_i     (rs2_v),
    .dec_rs2_adr_i   (rs2_adr),
    .dec_serial_i    (serial),
    .exe_rd_v_q_i    (rd_v),
    .exe_rd_adr_q_i  (rd_adr),
    .exe_is_load_q_i (is_load),
    .exe_lsu_busy_i  (lsu_busy),
    .exe_flush_req_i (flush_req),
    .if_stall_o      (if_stall),
    .dec_stall_o     (dec_stall),
    .dec_bubble_o    (dec_bubble),
    .flush_v_q_o     (flush_v_q),
`ifdef DEC_PIPE_CTRL_PERF_EN
    .perf_ld_stall_o     (perf_ld),
    .perf_serial_stall_o (perf_ser),
    .perf_flush_o        (perf_fl),
`endif
    .state_q_o       (state_q)
  );

  // Monitor: every cycle presents a response; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (if_stall !== e.stall || dec_stall !== e.stall || dec_bubble !== e.bubble ||
            flush_v_q !== e.flush_v || state_q !== e.state) begin
          miscompares++;
          $display("FAIL vec%0d: got if_stall=%b dec_stall=%b bubble=%b flush_v=%b state=%0d, want stall=%b bubble=%b flush_v=%b state=%0d",
                   vectors, if_stall, dec_stall, dec_bubble, flush_v_q, state_q,
                   e.stall, e.bubble, e.flush_v, e.state);
        end
      end
    end
  end

  task automatic idle();
    dec_valid = 0; rs1_v = 0; rs1_adr = 0; rs2_v = 0; rs2_adr = 0; serial = 0;
    rd_v = 0; rd_adr = 0; is_load = 0; lsu_busy = 0; flush_req = 0;
  endtask

  // Load with rd in execute and a consumer reading rs1 in decode.
  task automatic hazard(input logic [4:0] rd, input logic [4:0] rs1);
    idle();
    rd_v = 1; is_load = 1; rd_adr = rd;
    dec_valid = 1; rs1_v = 1; rs1_adr = rs1;
  endtask

  task automatic expect_cyc(input logic s, input logic b, input logic f, input logic [1:0] st);
    exp_t e;
    e.stall = s; e.bubble = b; e.flush_v = f; e.state = st;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    expect_cyc(0, 0, 0, 0);
    reset = 0;

    // Load-use through rs1: RUN stall cycle, then one LD_STALL cycle.
    hazard(5, 5);            expect_cyc(1, 1, 0, 0);
    rd_v = 0; is_load = 0;   expect_cyc(1, 1, 0, 1);
                             expect_cyc(0, 0, 0, 0);
    // rs2 address matches but rs2 not read: no hazard.
    hazard(5, 0); rs1_v = 0; rs2_adr = 5; expect_cyc(0, 0, 0, 0);
    rs2_v = 1;               expect_cyc(1, 1, 0, 0);
    idle();                  expect_cyc(1, 1, 0, 1);
                             expect_cyc(0, 0, 0, 0);
    // x0 never hazards; invalid decode never hazards.
    hazard(0, 0);            expect_cyc(0, 0, 0, 0);
    hazard(7, 7); dec_valid = 0; expect_cyc(0, 0, 0, 0);

    // Serializing instruction: two drain cycles, then RUN unstalled.
    idle(); dec_valid = 1; serial = 1; expect_cyc(0, 0, 0, 0);
    serial = 0;              expect_cyc(1, 1, 0, 2);
                             expect_cyc(1, 1, 0, 2);
                             expect_cyc(0, 0, 0, 0);

    // Flush while SERIAL counter is 2.
    serial = 1;              expect_cyc(0, 0, 0, 0);
    serial = 0; flush_req = 1; expect_cyc(0, 0, 0, 2);
    flush_req = 0;           expect_cyc(0, 0, 1, 3);
                             expect_cyc(0, 0, 0, 0);

    // Back-to-back flushes.
    idle(); flush_req = 1;   expect_cyc(0, 0, 0, 0);
                             expect_cyc(0, 0, 1, 3);
    flush_req = 0;           expect_cyc(0, 0, 1, 3);
                             expect_cyc(0, 0, 0, 0);

    // LSU busy with a load-use hazard: stall without bubble, then LD_STALL.
    hazard(9, 9); lsu_busy = 1; expect_cyc(1, 0, 0, 0);
                             expect_cyc(1, 0, 0, 0);
                             expect_cyc(1, 0, 0, 0);
    lsu_busy = 0;            expect_cyc(1, 1, 0, 0);
    rd_v = 0; is_load = 0;   expect_cyc(1, 1, 0, 1);
                             expect_cyc(0, 0, 0, 0);

    // Serializing instruction held by LSU busy, SERIAL on first free cycle.
    idle(); dec_valid = 1; serial = 1; lsu_busy = 1; expect_cyc(1, 0, 0, 0);
                             expect_cyc(1, 0, 0, 0);
    lsu_busy = 0;            expect_cyc(0, 0, 0, 0);
    serial = 0;              expect_cyc(1, 1, 0, 2);
                             expect_cyc(1, 1, 0, 2);
                             expect_cyc(0, 0, 0, 0);

    // Flush beats busy and hazard in the same cycle.
    hazard(3, 3); lsu_busy = 1; flush_req = 1; expect_cyc(0, 0, 0, 0);
    idle();                  expect_cyc(0, 0, 1, 3);
                             expect_cyc(0, 0, 0, 0);

    // Flush from LD_STALL.
    hazard(4, 4);            expect_cyc(1, 1, 0, 0);
    idle(); flush_req = 1;   expect_cyc(0, 0, 0, 1);
    flush_req = 0;           expect_cyc(0, 0, 1, 3);
                             expect_cyc(0, 0, 0, 0);

    // Reset during LD_STALL.
    hazard(6, 6);            expect_cyc(1, 1, 0, 0);
    idle(); reset = 1;       expect_cyc(1, 1, 0, 1);
    reset = 0;               expect_cyc(0, 0, 0, 0);

    // Reset during SERIAL clears the drain counter.
    dec_valid = 1; serial = 1; expect_cyc(0, 0, 0, 0);
    serial = 0; reset = 1;   expect_cyc(1, 1, 0, 2);
    reset = 0;               expect_cyc(0, 0, 0, 0);
                             expect_cyc(0, 0, 0, 0);

    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
